// File: rtl/vga_sync_decoder_pkg.sv
// Shared 640x480@60 timing constants and the lock state encoding.
// The sync generator uses the same constants, so the two always agree on geometry.
// Contents: VGA_* timing localparams, sync_state_t, and the timeout_ticks() helper.
package vga_sync_decoder_pkg;

    // Horizontal timing in pixel ticks. The line starts with the sync pulse,
    // followed by back porch, visible area and front porch.
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = 800;

    // Vertical timing in lines, with the same ordering as horizontal.
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = 525;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // Line timeout threshold: two nominal lines without an hsync edge.
    // The line counter saturates at 2^bits-1. With the default 10-bit counter,
    // 1600 is not reachable, so the threshold is clamped to the saturation
    // value. This keeps the timeout reachable for any counter width.
    function automatic int timeout_ticks(input int h_total, input int bits);
        int cap;
        cap = (1 << bits) - 1;
        return (2 * h_total > cap) ? cap : 2 * h_total;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Purpose: 2-FF synchronizer, polarity normalize, and a pixEn-qualified leading-edge pulse.
// Latency: 2 mclk through the synchronizer, then the edge pulses on the next pixEn.
// Backpressure: none; this is a free-running sampler.
// Ports: mclk/reset (async active-low), pixEn tick, din raw sync, rise one-mclk edge pulse.
module sync_edge_detect
    import vga_sync_decoder_pkg::*;
#(
    parameter bit POL = 1'b0          // asserted level of din
) (
    input  logic mclk,
    input  logic reset,
    input  logic pixEn,
    input  logic din,
    output logic rise
);

    logic meta;
    logic synced;
    logic prev;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            prev   <= 1'b0;
        end else begin
            // Normalize at the first flop so that everything downstream sees asserted=1.
            meta   <= (din == POL);
            synced <= meta;
            // prev holds the level seen at the last pixel tick. Edges are
            // therefore measured in pixel time, not in mclk time.
            if (pixEn) begin
                prev <= synced;
            end
        end
    end

    assign rise = pixEn & synced & ~prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Purpose: recover pixel coordinates and display enable from incoming HSYNC/VSYNC, and check timing and lock.
// Latency: sync edge = 2 mclk + next pixEn; coordinates registered 1 mclk after the count update.
// Backpressure: none; consumes every pixEn, and all status outputs are single-cycle pulses or levels.
// Ports: mclk, reset (async active-low), pixEn, hsync, vsync in;
//        x_pixel, y_pixel, vOn, frameStart, locked, timingErr, lineLen, frameLen out.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int bitsPosicion = 10,
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BACK       = VGA_H_BACK,
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int V_VISIBLE    = VGA_V_VISIBLE,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BACK       = VGA_V_BACK,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int SYNC_POL     = 0,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic                    mclk,
    input  logic                    reset,
    input  logic                    pixEn,
    input  logic                    hsync,
    input  logic                    vsync,
    output logic [bitsPosicion-1:0] x_pixel,
    output logic [bitsPosicion-1:0] y_pixel,
    output logic                    vOn,
    output logic                    frameStart,
    output logic                    locked,
    output logic                    timingErr,
    output logic [bitsPosicion-1:0] lineLen,
    output logic [bitsPosicion-1:0] frameLen
);

    typedef logic [bitsPosicion-1:0] cnt_t;

    localparam cnt_t CNT_MAX      = {bitsPosicion{1'b1}};
    localparam cnt_t H_TOTAL_C    = cnt_t'(H_TOTAL);
    localparam cnt_t V_TOTAL_C    = cnt_t'(V_TOTAL);
    localparam cnt_t H_START      = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t H_END        = cnt_t'(H_SYNC + H_BACK + H_VISIBLE);
    localparam cnt_t V_START      = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t V_END        = cnt_t'(V_SYNC + V_BACK + V_VISIBLE);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(timeout_ticks(H_TOTAL, bitsPosicion) - 1);
    localparam logic [7:0] GOOD_LAST = 8'(LOCK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic h_edge;
    logic v_edge;

    sync_edge_detect #(.POL(SYNC_POL != 0)) u_hsync_edge (
        .mclk  (mclk),
        .reset (reset),
        .pixEn (pixEn),
        .din   (hsync),
        .rise  (h_edge)
    );

    sync_edge_detect #(.POL(SYNC_POL != 0)) u_vsync_edge (
        .mclk  (mclk),
        .reset (reset),
        .pixEn (pixEn),
        .din   (vsync),
        .rise  (v_edge)
    );

    // ------------------------------------------------------------------
    // Line / frame counters
    // ------------------------------------------------------------------
    cnt_t h_count;
    cnt_t v_count;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            h_count    <= '0;
            v_count    <= '0;
            lineLen    <= '0;
            frameLen   <= '0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= v_edge;

            if (h_edge) begin
                lineLen <= h_count + 1'b1;
                h_count <= '0;
            end else if (pixEn && h_count != CNT_MAX) begin
                h_count <= h_count + 1'b1;
            end

            // A vsync edge normally lands on the same tick as an hsync edge.
            // The vsync edge takes priority, so the first line of a frame is line 0.
            if (v_edge) begin
                frameLen <= v_count + 1'b1;
                v_count  <= '0;
            end else if (h_edge && v_count != CNT_MAX) begin
                v_count <= v_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timing checks
    // ------------------------------------------------------------------
    logic line_err;     // some line in the current frame had the wrong length
    logic first_line;   // the line in progress started while searching; do not judge it
    logic line_bad;
    logic frame_len_ok;
    logic timeout;

    assign line_bad     = h_edge & ~first_line & (h_count + 1'b1 != H_TOTAL_C);
    assign frame_len_ok = (v_count + 1'b1 == V_TOTAL_C);
    // Fires on the single tick where the counter reaches the threshold.
    // When saturated, the counter no longer matches, so this reports once per loss of signal.
    assign timeout      = pixEn & ~h_edge & (h_count == TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    sync_state_t state;
    logic [7:0]  good_cnt;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state      <= SEARCH;
            good_cnt   <= '0;
            line_err   <= 1'b0;
            first_line <= 1'b1;
            locked     <= 1'b0;
            timingErr  <= 1'b0;
        end else begin
            timingErr <= 1'b0;

            // The frame verdict at a vsync edge must include the line that ends
            // on that edge. That is why line_bad is also folded into the VERIFY decision below.
            if (v_edge) begin
                line_err <= 1'b0;
            end else if (line_bad) begin
                line_err <= 1'b1;
            end

            if (state == SEARCH) begin
                first_line <= 1'b1;
            end else if (h_edge) begin
                first_line <= 1'b0;
            end

            if (timeout) begin
                if (state != SEARCH) begin
                    timingErr <= 1'b1;
                end
                state  <= SEARCH;
                locked <= 1'b0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (v_edge) begin
                            state    <= VERIFY;
                            good_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        if (v_edge) begin
                            if (!line_err && !line_bad && frame_len_ok) begin
                                if (good_cnt == GOOD_LAST) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end else begin
                                    good_cnt <= good_cnt + 1'b1;
                                end
                            end else begin
                                state     <= SEARCH;
                                timingErr <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (line_bad || (v_edge && !frame_len_ok)) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            timingErr <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Coordinates
    // ------------------------------------------------------------------
    logic h_act;
    logic v_act;

    assign h_act = (h_count >= H_START) && (h_count < H_END);
    assign v_act = (v_count >= V_START) && (v_count < V_END);

    // The counters only move on pixEn. Resampling every mclk therefore
    // holds the coordinates steady between ticks.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            x_pixel <= '0;
            y_pixel <= '0;
            vOn     <= 1'b0;
        end else begin
            x_pixel <= h_act ? h_count - H_START : '0;
            y_pixel <= v_act ? v_count - V_START : '0;
            vOn     <= locked & h_act & v_act;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
module tb_vga_sync_decoder;

    // Reduced geometry so that multi-frame scenarios stay short:
    // window h 5..14, v 4..9; lines of 20 ticks, frames of 12 lines.
    localparam int BITS = 10;
    localparam int HV = 10, HS = 3, HB = 2, HT = 20;
    localparam int VV = 6,  VS = 2, VB = 2, VT = 12;
    localparam int POL = 0;
    localparam int LF = 2;

    logic            mclk  = 1'b0;
    logic            reset = 1'b1;
    logic            pixEn = 1'b0;
    logic            hsync = 1'b1;
    logic            vsync = 1'b1;
    logic [BITS-1:0] x_pixel, y_pixel, lineLen, frameLen;
    logic            vOn, frameStart, locked, timingErr;

    always #5 mclk = ~mclk;

    vga_sync_decoder #(
        .bitsPosicion (BITS),
        .H_VISIBLE    (HV), .H_SYNC (HS), .H_BACK (HB), .H_TOTAL (HT),
        .V_VISIBLE    (VV), .V_SYNC (VS), .V_BACK (VB), .V_TOTAL (VT),
        .SYNC_POL     (POL),
        .LOCK_FRAMES  (LF)
    ) dut (
        .mclk       (mclk),
        .reset      (reset),
        .pixEn      (pixEn),
        .hsync      (hsync),
        .vsync      (vsync),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .vOn        (vOn),
        .frameStart (frameStart),
        .locked     (locked),
        .timingErr  (timingErr),
        .lineLen    (lineLen),
        .frameLen   (frameLen)
    );

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    logic fs_last = 1'b0;

    // Generator state. dh/dv are the counts the decoder should hold after a step.
    // The decoder sees each sync edge one pixel tick after it is driven.
    int gh, gv, lh, lv, dh, dv, cur_hlen, cur_vlen;
    bit stall, short_line, short_frame;

    typedef struct {
        int v;
        int h;
        int x;
        int y;
        bit von;
    } coord_vec_t;
    coord_vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic gen_restart();
        gh = 0; gv = 0; lh = 0; lv = 0; dh = 0; dv = 0;
        cur_hlen = HT; cur_vlen = VT;
        stall = 0; short_line = 0; short_frame = 0;
    endtask

    // One pixel tick: drive syncs with pixEn, catch the pulses while they are
    // high, and return once the coordinate registers have updated.
    task automatic step();
        logic hs_a, vs_a;
        @(negedge mclk);
        hs_a = !stall && (gh < HS);
        vs_a = !stall && (gv < VS);
        hsync = (POL != 0) ? hs_a : ~hs_a;
        vsync = (POL != 0) ? vs_a : ~vs_a;
        pixEn = 1'b1;
        dh = lh; dv = lv;
        lh = gh; lv = gv;
        if (!stall) begin
            gh++;
            if (gh == cur_hlen) begin
                gh = 0;
                cur_hlen = short_line ? HT - 1 : HT;
                short_line = 0;
                gv++;
                if (gv == cur_vlen) begin
                    gv = 0;
                    cur_vlen = short_frame ? VT - 1 : VT;
                    short_frame = 0;
                end
            end
        end
        @(negedge mclk);
        pixEn = 1'b0;
        fs_last = frameStart;
        if (timingErr) err_cnt++;
        @(negedge mclk);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!fs_last && n < 400);
        if (!fs_last) begin
            total++;
            bad++;
            $display("FAIL %s: no frameStart within 400 pixel ticks", tag);
        end
    endtask

    task automatic wait_err(input int e0, input int limit);
        int n;
        n = 0;
        while (err_cnt == e0 && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        int e0;
        tbl[0] = '{v: 3,  h: 7,  x: 2, y: 0, von: 1'b0};
        tbl[1] = '{v: 4,  h: 4,  x: 0, y: 0, von: 1'b0};
        tbl[2] = '{v: 4,  h: 5,  x: 0, y: 0, von: 1'b1};
        tbl[3] = '{v: 6,  h: 10, x: 5, y: 2, von: 1'b1};
        tbl[4] = '{v: 9,  h: 14, x: 9, y: 5, von: 1'b1};
        tbl[5] = '{v: 9,  h: 15, x: 0, y: 5, von: 1'b0};
        tbl[6] = '{v: 10, h: 7,  x: 2, y: 0, von: 1'b0};
        gen_restart();

        // ---- Reset state, then lock at the third vsync edge ----
        #3 reset = 1'b0;
        #20;
        chk("rst_x", x_pixel, 0);
        chk("rst_y", y_pixel, 0);
        chk("rst_vOn", vOn, 0);
        chk("rst_frameStart", frameStart, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timingErr", timingErr, 0);
        chk("rst_lineLen", lineLen, 0);
        chk("rst_frameLen", frameLen, 0);
        @(negedge mclk);
        reset = 1'b1;

        wait_frame("A1");
        chk("A1_locked", locked, 0);
        wait_frame("A2");
        chk("A2_locked", locked, 0);
        chk("A2_frameLen", frameLen, VT);
        wait_frame("A3");
        chk("A3_locked", locked, 1);
        chk("A3_lineLen", lineLen, HT);
        chk("A3_frameLen", frameLen, VT);
        chk("A_no_err", err_cnt, 0);

        // ---- Coordinate table while locked ----
        for (int i = 0; i < 7; i++) begin
            int n;
            n = 0;
            while (!(dv == tbl[i].v && dh == tbl[i].h) && n < 400) begin
                step();
                n++;
            end
            if (n >= 400) begin
                total++;
                bad++;
                $display("FAIL coord_seek[%0d]: position %0d,%0d never reached", i, tbl[i].v, tbl[i].h);
            end
            chk($sformatf("x[%0d]", i), x_pixel, tbl[i].x);
            chk($sformatf("y[%0d]", i), y_pixel, tbl[i].y);
            chk($sformatf("vOn[%0d]", i), vOn, tbl[i].von);
            repeat (2) @(negedge mclk);
            chk($sformatf("x_hold[%0d]", i), x_pixel, tbl[i].x);
        end
        chk("B_no_err", err_cnt, 0);

        // ---- Short line while locked: error, then relock after 3 vsync edges ----
        e0 = err_cnt;
        short_line = 1;
        wait_err(e0, 80);
        chk("C_err", err_cnt - e0, 1);
        chk("C_locked_drop", locked, 0);
        wait_frame("C1");
        chk("C1_locked", locked, 0);
        wait_frame("C2");
        chk("C2_locked", locked, 0);
        wait_frame("C3");
        chk("C3_locked", locked, 1);
        chk("C_err_once", err_cnt - e0, 1);

        // ---- Short frame while in VERIFY with goodCnt=1 ----
        e0 = err_cnt;
        short_line = 1;
        wait_err(e0, 80);
        chk("D_line_err", err_cnt - e0, 1);
        wait_frame("Da");
        short_frame = 1;
        wait_frame("Db");
        chk("Db_locked", locked, 0);
        chk("Db_err", err_cnt - e0, 1);
        wait_frame("Dc");
        chk("Dc_err", err_cnt - e0, 2);
        chk("Dc_frameLen", frameLen, VT - 1);
        chk("Dc_locked", locked, 0);
        wait_frame("Dd");
        wait_frame("De");
        chk("De_locked", locked, 0);
        wait_frame("Df");
        chk("Df_locked", locked, 1);

        // ---- Loss of hsync while locked: single timeout error ----
        e0 = err_cnt;
        stall = 1;
        repeat (80) step();
        stall = 0;
        chk("E_err", err_cnt - e0, 1);
        chk("E_locked", locked, 0);
        chk("E_lineLen", lineLen, HT);
        repeat (30) step();

        // ---- Async reset between clock edges, then coincident edges ----
        @(negedge mclk);
        #2 reset = 1'b0;
        #1;
        chk("F_x", x_pixel, 0);
        chk("F_y", y_pixel, 0);
        chk("F_vOn", vOn, 0);
        chk("F_frameStart", frameStart, 0);
        chk("F_locked", locked, 0);
        chk("F_timingErr", timingErr, 0);
        chk("F_lineLen", lineLen, 0);
        chk("F_frameLen", frameLen, 0);
        #1 reset = 1'b1;
        hsync = (POL != 0) ? 1'b0 : 1'b1;
        vsync = (POL != 0) ? 1'b0 : 1'b1;
        gen_restart();
        step();
        chk("F_fs_step1", fs_last, 0);
        step();
        chk("F_fs_coincide", fs_last, 1);
        e0 = err_cnt;
        wait_frame("F2");
        chk("F2_frameLen", frameLen, VT);
        chk("F2_locked", locked, 0);
        wait_frame("F3");
        chk("F3_locked", locked, 1);
        chk("F_no_err", err_cnt - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
